// File: rtl/ahb_pm_pkg.sv
// Shared types and constants for the AHB-Lite policy monitor.
// State encodings are plain localparams so legacy tooling can decode them.
package ahb_pm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CHECK = 3'd1;
  localparam state_t S_DCHK  = 3'd2;
  localparam state_t S_ISSUE = 3'd3;
  localparam state_t S_WAIT  = 3'd4;
  localparam state_t S_ERR1  = 3'd5;
  localparam state_t S_ERR2  = 3'd6;

  typedef logic [1:0] log_type_t;

  localparam log_type_t APU_DENY  = 2'b01;
  localparam log_type_t DPU_MATCH = 2'b10;

endpackage

// File: rtl/ahb_pm_log_fifo.sv
// Violation log FIFO: drops pushes when full (sticky overflow), clear beats push.
module ahb_pm_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale words are never observed.
  always_ff @(posedge hclk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ahb_policy_monitor.sv
// AHB-Lite transaction firewall: address/permission (APU) and write-data (DPU)
// policy checks, two-cycle ERROR on denial, and a violation log with counter.
module ahb_policy_monitor
  import ahb_pm_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MID_W     = 32,
  parameter int NUM_APU   = 16,
  parameter int NUM_DPU   = 16,
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W     = 16,
  parameter int ENFORCE   = 1
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic                             hsel_m,
  input  logic                             hwrite_m,
  input  logic [ADDR_W-1:0]                haddr_m,
  input  logic [MID_W-1:0]                 hmaster_m,
  input  logic [2:0]                       hsize_m,
  input  logic [DATA_W-1:0]                hwdata_m,
  output logic [DATA_W-1:0]                hrdata_m,
  output logic                             hready_m,
  output logic                             hresp_m,
  output logic                             hsel_s,
  output logic                             hwrite_s,
  output logic [ADDR_W-1:0]                haddr_s,
  output logic [MID_W-1:0]                 hmaster_s,
  output logic [2:0]                       hsize_s,
  output logic [DATA_W-1:0]                hwdata_s,
  input  logic [DATA_W-1:0]                hrdata_s,
  input  logic                             hready_s,
  input  logic                             hresp_s,
  input  logic [NUM_APU-1:0][MID_W-1:0]    apu_mid,
  input  logic [NUM_APU-1:0][ADDR_W-1:0]   apu_addr,
  input  logic [NUM_APU-1:0][ADDR_W-1:0]   apu_mask,
  input  logic [NUM_APU-1:0][1:0]          apu_perm,
  input  logic [NUM_DPU-1:0][MID_W-1:0]    dpu_mid,
  input  logic [NUM_DPU-1:0][ADDR_W-1:0]   dpu_addr,
  input  logic [NUM_DPU-1:0][ADDR_W-1:0]   dpu_amask,
  input  logic [NUM_DPU-1:0][DATA_W-1:0]   dpu_data,
  input  logic [NUM_DPU-1:0][DATA_W-1:0]   dpu_dmask,
  output logic                             log_valid,
  input  logic                             log_ready,
  output logic [1:0]                       log_type,
  output logic [MID_W-1:0]                 log_mid,
  output logic [ADDR_W-1:0]                log_addr,
  output logic                             log_overflow,
  input  logic                             log_clr,
  output logic [CNT_W-1:0]                 viol_count,
  output logic                             irq
);

  typedef struct packed {
    log_type_t         typ;
    logic [MID_W-1:0]  mid;
    logic [ADDR_W-1:0] addr;
  } log_entry_t;

  localparam int ENTRY_W = $bits(log_entry_t);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cap_addr;
  logic [MID_W-1:0]    cap_mid;
  logic [2:0]          cap_size;
  logic [DATA_W-1:0]   cap_data;
  logic                cap_write;
  logic                capture;
  logic                privileged, apu_viol, dpu_viol;
  logic [NUM_APU-1:0]  apu_hit;
  logic [NUM_DPU-1:0]  dpu_hit;
  logic                push;
  log_type_t           push_type;
  log_entry_t          push_entry, head_entry;
  logic [ENTRY_W-1:0]  head_bits;

  for (genvar i = 0; i < NUM_APU; i++) begin : g_apu
    logic [ADDR_W-1:0] lo, hi;
    assign lo = apu_addr[i] & ~apu_mask[i];
    assign hi = apu_addr[i] |  apu_mask[i];
    assign apu_hit[i] = (apu_mid[i] == cap_mid) && (cap_addr >= lo) && (cap_addr <= hi)
                        && (cap_write ? apu_perm[i][1] : apu_perm[i][0]);
  end

  for (genvar j = 0; j < NUM_DPU; j++) begin : g_dpu
    logic [ADDR_W-1:0] lo, hi;
    assign lo = dpu_addr[j] & ~dpu_amask[j];
    assign hi = dpu_addr[j] |  dpu_amask[j];
    assign dpu_hit[j] = (dpu_mid[j] == cap_mid) && (cap_addr >= lo) && (cap_addr <= hi)
                        && ((cap_data & ~dpu_dmask[j]) == dpu_data[j]);
  end

  assign privileged = (cap_mid < MID_W'(2));
  assign apu_viol   = !privileged && !(|apu_hit);
  assign dpu_viol   = !privileged &&  (|dpu_hit);

  // A new address phase is accepted whenever the master sees hready_m high.
  assign capture = hsel_m && ((state_q == S_IDLE) || (state_q == S_ERR2) ||
                              ((state_q == S_WAIT) && hready_s));

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_type = APU_DENY;
    case (state_q)
      S_IDLE:  if (hsel_m) state_d = S_CHECK;
      S_CHECK: begin
        push = apu_viol;
        if (apu_viol && (ENFORCE != 0)) state_d = S_ERR1;
        else if (cap_write)              state_d = S_DCHK;
        else                             state_d = S_ISSUE;
      end
      S_DCHK: begin
        push      = dpu_viol;
        push_type = DPU_MATCH;
        state_d   = (dpu_viol && (ENFORCE != 0)) ? S_ERR1 : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (hready_s) state_d = hsel_m ? S_CHECK : S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = hsel_m ? S_CHECK : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      cap_addr  <= '0;
      cap_mid   <= '0;
      cap_size  <= '0;
      cap_write <= 1'b0;
      cap_data  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cap_addr  <= haddr_m;
        cap_mid   <= hmaster_m;
        cap_size  <= hsize_m;
        cap_write <= hwrite_m;
      end
      // Write data arrives in the cycle after the address phase.
      if (state_q == S_CHECK) cap_data <= hwdata_m;
    end
  end

  always_comb begin
    hready_m  = 1'b0;
    hresp_m   = 1'b0;
    hrdata_m  = '0;
    hsel_s    = 1'b0;
    hwrite_s  = 1'b0;
    haddr_s   = '0;
    hmaster_s = '0;
    hsize_s   = '0;
    hwdata_s  = '0;
    case (state_q)
      S_IDLE: hready_m = 1'b1;
      S_ISSUE: begin
        hsel_s    = 1'b1;
        hwrite_s  = cap_write;
        haddr_s   = cap_addr;
        hmaster_s = cap_mid;
        hsize_s   = cap_size;
      end
      S_WAIT: begin
        hwdata_s = cap_data;
        hready_m = hready_s;
        hresp_m  = hresp_s;
        hrdata_m = hrdata_s;
      end
      S_ERR1: hresp_m = 1'b1;
      S_ERR2: begin
        hready_m = 1'b1;
        hresp_m  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                         viol_count <= '0;
    else if (log_clr)                   viol_count <= '0;
    else if (push && (viol_count != '1)) viol_count <= viol_count + CNT_W'(1);
  end

  assign push_entry = '{typ: push_type, mid: cap_mid, addr: cap_addr};

  ahb_pm_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_log_fifo (
    .hclk      (hclk),
    .hreset    (hreset),
    .push      (push),
    .push_data (push_entry),
    .pop       (log_valid && log_ready),
    .clr       (log_clr),
    .valid     (log_valid),
    .data      (head_bits),
    .overflow  (log_overflow)
  );

  assign head_entry = log_entry_t'(head_bits);
  assign log_type   = head_entry.typ;
  assign log_mid    = head_entry.mid;
  assign log_addr   = head_entry.addr;
  assign irq        = log_valid;

endmodule

// File: tb/tb_ahb_policy_monitor.sv
// Directed bench: instance A enforces (8-deep log), instance B is log-only (2-deep log).
module tb_ahb_policy_monitor;

  localparam int NP = 2;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  logic        hsel_a, hsel_b, hwrite_m;
  logic [31:0] haddr_m, hmaster_m, hwdata_m;
  logic [2:0]  hsize_m;
  logic [31:0] hrdata_s;
  logic        hready_s, hresp_s;

  logic [NP-1:0][31:0] apu_mid, apu_addr, apu_mask;
  logic [NP-1:0][1:0]  apu_perm;
  logic [NP-1:0][31:0] dpu_mid, dpu_addr, dpu_amask, dpu_data, dpu_dmask;

  logic [31:0] hrdata_m_a, haddr_s_a, hmaster_s_a, hwdata_s_a, log_mid_a, log_addr_a;
  logic [31:0] hrdata_m_b, haddr_s_b, hmaster_s_b, hwdata_s_b, log_mid_b, log_addr_b;
  logic        hready_m_a, hresp_m_a, hsel_s_a, hwrite_s_a, log_valid_a, log_overflow_a, irq_a;
  logic        hready_m_b, hresp_m_b, hsel_s_b, hwrite_s_b, log_valid_b, log_overflow_b, irq_b;
  logic [2:0]  hsize_s_a, hsize_s_b;
  logic [1:0]  log_type_a, log_type_b;
  logic [15:0] viol_a, viol_b;
  logic        log_ready_a, log_ready_b, log_clr_a, log_clr_b;

  ahb_policy_monitor #(.NUM_APU(NP), .NUM_DPU(NP), .LOG_DEPTH(8), .ENFORCE(1)) dut_a (
    .hclk(hclk), .hreset(hreset), .hsel_m(hsel_a), .hwrite_m(hwrite_m), .haddr_m(haddr_m),
    .hmaster_m(hmaster_m), .hsize_m(hsize_m), .hwdata_m(hwdata_m), .hrdata_m(hrdata_m_a),
    .hready_m(hready_m_a), .hresp_m(hresp_m_a), .hsel_s(hsel_s_a), .hwrite_s(hwrite_s_a),
    .haddr_s(haddr_s_a), .hmaster_s(hmaster_s_a), .hsize_s(hsize_s_a), .hwdata_s(hwdata_s_a),
    .hrdata_s(hrdata_s), .hready_s(hready_s), .hresp_s(hresp_s),
    .apu_mid(apu_mid), .apu_addr(apu_addr), .apu_mask(apu_mask), .apu_perm(apu_perm),
    .dpu_mid(dpu_mid), .dpu_addr(dpu_addr), .dpu_amask(dpu_amask), .dpu_data(dpu_data),
    .dpu_dmask(dpu_dmask), .log_valid(log_valid_a), .log_ready(log_ready_a),
    .log_type(log_type_a), .log_mid(log_mid_a), .log_addr(log_addr_a),
    .log_overflow(log_overflow_a), .log_clr(log_clr_a), .viol_count(viol_a), .irq(irq_a)
  );

  ahb_policy_monitor #(.NUM_APU(NP), .NUM_DPU(NP), .LOG_DEPTH(2), .ENFORCE(0)) dut_b (
    .hclk(hclk), .hreset(hreset), .hsel_m(hsel_b), .hwrite_m(hwrite_m), .haddr_m(haddr_m),
    .hmaster_m(hmaster_m), .hsize_m(hsize_m), .hwdata_m(hwdata_m), .hrdata_m(hrdata_m_b),
    .hready_m(hready_m_b), .hresp_m(hresp_m_b), .hsel_s(hsel_s_b), .hwrite_s(hwrite_s_b),
    .haddr_s(haddr_s_b), .hmaster_s(hmaster_s_b), .hsize_s(hsize_s_b), .hwdata_s(hwdata_s_b),
    .hrdata_s(hrdata_s), .hready_s(hready_s), .hresp_s(hresp_s),
    .apu_mid(apu_mid), .apu_addr(apu_addr), .apu_mask(apu_mask), .apu_perm(apu_perm),
    .dpu_mid(dpu_mid), .dpu_addr(dpu_addr), .dpu_amask(dpu_amask), .dpu_data(dpu_data),
    .dpu_dmask(dpu_dmask), .log_valid(log_valid_b), .log_ready(log_ready_b),
    .log_type(log_type_b), .log_mid(log_mid_b), .log_addr(log_addr_b),
    .log_overflow(log_overflow_b), .log_clr(log_clr_b), .viol_count(viol_b), .irq(irq_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Runs one transfer; cycle 0 is the accepted address phase.
  task automatic xfer(input bit b, input bit wr, input logic [31:0] mid, input logic [31:0] addr,
                      input logic [31:0] data, output int done, output logic err, output int err1,
                      output logic [31:0] rdata, output logic saw_sel, output logic [31:0] sel_addr,
                      output logic saw_wd);
    logic rdy, rsp;
    done = -1; err1 = -1; err = 1'b0; rdata = '0; saw_sel = 1'b0; sel_addr = '0; saw_wd = 1'b0;
    hwrite_m = wr; hmaster_m = mid; haddr_m = addr; hsize_m = 3'd2; hwdata_m = '0;
    if (b) hsel_b = 1'b1; else hsel_a = 1'b1;
    step();
    hsel_a = 1'b0; hsel_b = 1'b0;
    hwdata_m = wr ? data : '0;
    for (int c = 1; c < 20 && done < 0; c++) begin
      rdy = b ? hready_m_b : hready_m_a;
      rsp = b ? hresp_m_b  : hresp_m_a;
      if (b ? hsel_s_b : hsel_s_a) begin
        saw_sel  = 1'b1;
        sel_addr = b ? haddr_s_b : haddr_s_a;
      end
      if ((b ? hwdata_s_b : hwdata_s_a) != '0) saw_wd = 1'b1;
      if (rsp && err1 < 0) err1 = c;
      if (rdy) begin
        done  = c;
        err   = rsp;
        rdata = b ? hrdata_m_b : hrdata_m_a;
      end
      step();
    end
  endtask

  int          done, err1;
  logic        err, saw_sel, saw_wd;
  logic [31:0] rdata, sel_addr;

  initial begin
    hreset = 1'b1;
    hsel_a = 1'b0; hsel_b = 1'b0; hwrite_m = 1'b0; haddr_m = '0; hmaster_m = '0;
    hsize_m = '0; hwdata_m = '0;
    hrdata_s = 32'hCAFE_F00D; hready_s = 1'b1; hresp_s = 1'b0;
    log_ready_a = 1'b0; log_ready_b = 1'b0; log_clr_a = 1'b0; log_clr_b = 1'b0;
    apu_mid = '0; apu_addr = '0; apu_mask = '0; apu_perm = '0;
    dpu_mid = '0; dpu_addr = '0; dpu_amask = '0; dpu_data = '0; dpu_dmask = '0;
    apu_mid[0] = 32'd5; apu_addr[0] = 32'h1000; apu_mask[0] = 32'hFF; apu_perm[0] = 2'b01;
    step(); step();
    hreset = 1'b0;
    step();

    check("rst_hready", hready_m_a, 1'b1);
    check("rst_hresp", hresp_m_a, 1'b0);
    check("rst_hrdata", hrdata_m_a, 32'h0);
    check("rst_hsel_s", hsel_s_a, 1'b0);
    check("rst_log", {log_valid_a, log_overflow_a, irq_a}, 3'b000);
    check("rst_viol", viol_a, 16'h0);

    // Permitted read.
    xfer(0, 0, 32'd5, 32'h1080, 32'h0, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("rd_done", done, 3);
    check("rd_err", err, 1'b0);
    check("rd_data", rdata, 32'hCAFE_F00D);
    check("rd_fwd_addr", {saw_sel, sel_addr}, {1'b1, 32'h1080});
    check("rd_nolog", log_valid_a, 1'b0);

    // Upper range boundary allowed, one past denied.
    xfer(0, 0, 32'd5, 32'h10FF, 32'h0, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("rd_hi_ok", {done[3:0], err}, {4'd3, 1'b0});
    xfer(0, 0, 32'd5, 32'h1100, 32'h0, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("rd_past_deny", {done[3:0], err1[3:0], err, saw_sel}, {4'd3, 4'd2, 1'b1, 1'b0});
    check("rd_past_log", {log_type_a, log_mid_a, log_addr_a}, {2'b01, 32'd5, 32'h1100});
    log_ready_a = 1'b1; step(); log_ready_a = 1'b0;

    // Write without write permission.
    xfer(0, 1, 32'd5, 32'h1080, 32'h1, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("wr_apu_err1", err1, 2);
    check("wr_apu_done", {done[3:0], err}, {4'd3, 1'b1});
    check("wr_apu_nosel", saw_sel, 1'b0);
    check("wr_apu_log", {log_valid_a, irq_a, log_type_a, log_mid_a, log_addr_a},
          {1'b1, 1'b1, 2'b01, 32'd5, 32'h1080});
    check("wr_apu_viol", viol_a, 16'd2);
    log_ready_a = 1'b1; step(); log_ready_a = 1'b0;
    check("pop_empty", log_valid_a, 1'b0);

    // DPU pattern match.
    apu_perm[0] = 2'b11;
    dpu_mid[0] = 32'd5; dpu_addr[0] = 32'h1000; dpu_amask[0] = 32'hFF;
    dpu_data[0] = 32'hDEAD_0000; dpu_dmask[0] = 32'h0000_FFFF;
    xfer(0, 1, 32'd5, 32'h1080, 32'hDEAD_BEEF, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("dpu_err1", err1, 3);
    check("dpu_done", {done[3:0], err}, {4'd4, 1'b1});
    check("dpu_block", {saw_sel, saw_wd}, 2'b00);
    check("dpu_log", {log_valid_a, log_type_a, log_addr_a}, {1'b1, 2'b10, 32'h1080});
    check("dpu_viol", viol_a, 16'd3);
    log_ready_a = 1'b1; step(); log_ready_a = 1'b0;

    xfer(0, 1, 32'd5, 32'h1080, 32'h1234_5678, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("wr_ok_done", {done[3:0], err}, {4'd4, 1'b0});
    check("wr_ok_fwd", {saw_sel, saw_wd}, 2'b11);
    check("wr_ok_nolog", {log_valid_a, viol_a}, {1'b0, 16'd3});

    // Privileged master bypasses policies.
    xfer(0, 0, 32'd1, 32'h8000_0000, 32'h0, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("priv_rd", {done[3:0], err, saw_sel}, {4'd3, 1'b0, 1'b1});
    xfer(0, 1, 32'd1, 32'h8000_0000, 32'hDEAD_0000, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("priv_wr", {done[3:0], err, saw_sel}, {4'd4, 1'b0, 1'b1});
    check("priv_nolog", {log_valid_a, viol_a}, {1'b0, 16'd3});

    // Log-only instance with a 2-deep log.
    for (int k = 0; k < 3; k++) begin
      xfer(1, 1, 32'd7, 32'h2000 + 32'(4 * k), 32'h55, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
      check("lo_fwd", {done[3:0], err, saw_sel}, {4'd4, 1'b0, 1'b1});
    end
    check("lo_log", {log_valid_b, log_overflow_b, log_addr_b}, {1'b1, 1'b1, 32'h2000});
    check("lo_viol", viol_b, 16'd3);
    log_clr_b = 1'b1; step(); log_clr_b = 1'b0;
    check("lo_clr", {log_valid_b, log_overflow_b, viol_b}, {1'b0, 1'b0, 16'd0});

    // Reset while a write sits in DCHK, with one entry already logged.
    xfer(0, 1, 32'd7, 32'h3000, 32'h1, done, err, err1, rdata, saw_sel, sel_addr, saw_wd);
    check("pre_rst_log", log_valid_a, 1'b1);
    hwrite_m = 1'b1; hmaster_m = 32'd5; haddr_m = 32'h1080; hsel_a = 1'b1;
    step();
    hsel_a = 1'b0; hwdata_m = 32'h1;
    step();
    check("in_dchk", {hready_m_a, hresp_m_a}, 2'b00);
    hreset = 1'b1;
    step();
    check("rst_mid_bus", {hready_m_a, hresp_m_a, hsel_s_a}, 3'b100);
    check("rst_mid_log", {log_valid_a, viol_a}, {1'b0, 16'd0});
    hreset = 1'b0;
    step(); step();
    check("rst_mid_after", {hsel_s_a, log_valid_a}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
